// File: rtl/keycode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keycode_pkg : event type codes, key constants and FSM state type     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package keycode_pkg;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  localparam logic [7:0] KEY_NONE   = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_SWAP   = 2'd3
  } kes_state_e;

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_event_fifo : show-ahead FIFO, push accepted when full with pop   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q == {~rd_q[AW], rd_q[AW-1:0]});
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  // Storage is not reset, so hide stale contents while empty.
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/keycode_event_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keycode_event_sequencer : filters PIO keycode, emits press/release/  |
// | typematic repeat events into a show-ahead FIFO.        Rev 1.0       |
// +----------------------------------------------------------------------+
module keycode_event_sequencer #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000,
  parameter int DEPTH         = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       repeat_en,
  output logic       ev_valid,
  output logic [9:0] ev_data,
  input  logic       ev_ready,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [7:0] cur_key
);

  import keycode_pkg::*;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Counters fire at zero, so loading N-1 gives exactly N cycles between events.
  localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(REPEAT_RATE - 1);
  localparam logic [7:0]       STABLE_N  = 8'(STABLE_CYCLES);

  logic [7:0]       kc_q, stab_q, stab_d;
  logic [7:0]       cur_key_q, cur_key_d, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kes_state_e       state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             cand_vld;
  logic             push, pop, full, empty, drop;
  logic [1:0]       push_type;
  logic [7:0]       push_code;

  assign stab_d   = (keycode != kc_q) ? 8'd0 :
                    (stab_q == STABLE_N) ? stab_q : stab_q + 8'd1;
  assign cand_vld = (stab_q == STABLE_N) && (kc_q != cur_key_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    pend_d    = pend_q;
    push      = 1'b0;
    push_type = EV_PRESS;
    push_code = cur_key_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_vld) begin
          push      = 1'b1;
          push_code = kc_q;
          cur_key_d = kc_q;
          cnt_d     = DLY_LOAD;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (cand_vld) begin
          push      = 1'b1;
          push_type = EV_RELEASE;
          if (kc_q == KEY_NONE) begin
            cur_key_d = KEY_NONE;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            pend_d  = kc_q;
            state_d = ST_SWAP;
          end
        end else if (state_q == ST_REPEAT && !repeat_en) begin
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (repeat_en) begin
          push      = 1'b1;
          push_type = EV_REPEAT;
          cnt_d     = RATE_LOAD;
          state_d   = ST_REPEAT;
        end
      end
      ST_SWAP: begin
        // Press for the key latched when the swap began; filter output waits.
        push      = 1'b1;
        push_code = pend_q;
        cur_key_d = pend_q;
        cnt_d     = DLY_LOAD;
        state_d   = ST_DELAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop   = ev_ready && !empty;
  assign drop  = push && full && !pop;
  assign ovf_d = (drop && push_type != EV_REPEAT) ? 1'b1 :
                 ovf_clr ? 1'b0 : ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_q      <= KEY_NONE;
      stab_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_key_q <= KEY_NONE;
      pend_q    <= KEY_NONE;
      ovf_q     <= 1'b0;
    end else begin
      kc_q      <= keycode;
      stab_q    <= stab_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
    end
  end

  key_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  ({push_type, push_code}),
    .pop_i   (pop),
    .data_o  (ev_data),
    .empty_o (empty),
    .full_o  (full)
  );

  assign ev_valid = !empty;
  assign overflow = ovf_q;
  assign cur_key  = cur_key_q;

endmodule
`default_nettype wire

// File: tb/tb_keycode_event_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keycode_event_sequencer : random stimulus vs event-level model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_keycode_event_sequencer;

  localparam int S = 2;
  localparam int D = 10;
  localparam int R = 4;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       repeat_en = 1'b0;
  logic       ev_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       ev_valid, overflow;
  logic [9:0] ev_data;
  logic [7:0] cur_key;

  int n_vec = 0;
  int n_err = 0;

  keycode_event_sequencer #(
    .STABLE_CYCLES (S),
    .REPEAT_DELAY  (D),
    .REPEAT_RATE   (R),
    .DEPTH         (N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keycode   (keycode),
    .repeat_en (repeat_en),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_ready  (ev_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .cur_key   (cur_key)
  );

  always #5 clk = ~clk;

  // Reference: keycode history, the held key, time since the last
  // press/repeat, and a queue standing in for the event buffer.
  logic [7:0] hist[$];
  logic [9:0] m_q[$];
  logic [7:0] m_key, m_pend;
  bit         m_swap, m_rep, m_due, m_ovf;
  int         m_age;
  logic [7:0] keys [7] = '{8'h00, 8'h00, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back(8'h00);
    m_q.delete();
    m_key = 8'h00; m_pend = 8'h00;
    m_swap = 0; m_rep = 0; m_due = 0; m_ovf = 0; m_age = 0;
  endfunction

  function automatic void model_edge();
    logic [7:0] kc;
    logic [9:0] ev;
    bit stable, cand, have_ev, set;
    int thr;
    kc = hist[hist.size()-1];
    stable = 1;
    for (int i = 0; i <= S; i++) if (hist[hist.size()-1-i] != kc) stable = 0;
    cand = stable && (kc != m_key);
    have_ev = 0;
    ev = '0;
    if (m_swap) begin
      ev = {2'b01, m_pend}; have_ev = 1;
      m_key = m_pend; m_swap = 0; m_age = 0; m_rep = 0; m_due = 0;
    end else if (m_key == 8'h00) begin
      if (cand) begin
        ev = {2'b01, kc}; have_ev = 1;
        m_key = kc; m_age = 0; m_rep = 0; m_due = 0;
      end
    end else if (cand) begin
      ev = {2'b10, m_key}; have_ev = 1;
      if (kc == 8'h00) m_key = 8'h00;
      else begin m_pend = kc; m_swap = 1; end
    end else if (m_rep && !repeat_en) begin
      m_rep = 0; m_due = 1;
    end else begin
      thr = m_rep ? R : D;
      if (repeat_en && (m_due || m_age + 1 >= thr)) begin
        ev = {2'b11, m_key}; have_ev = 1;
        m_rep = 1; m_due = 0; m_age = 0;
      end else m_age++;
    end
    set = 0;
    if (ev_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (have_ev) begin
      if (m_q.size() < N) m_q.push_back(ev);
      else if (ev[9:8] != 2'b11) set = 1;
    end
    if (set) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    hist.push_back(keycode);
    if (hist.size() > S + 2) void'(hist.pop_front());
  endfunction

  task automatic cmp_outputs();
    check_eq("ev_valid", {31'd0, ev_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) check_eq("ev_data", {22'd0, ev_data}, {22'd0, m_q[0]});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_eq("cur_key", {24'd0, cur_key}, {24'd0, m_key});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    keycode = 8'h00;
    #1;
    model_reset();
    check_eq("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check_eq("rst_ev_data", {22'd0, ev_data}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("rst_cur_key", {24'd0, cur_key}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic hold(input logic [7:0] k, input int cycles);
    keycode = k;
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    int lat;
    logic [9:0] lat_data;
    int hlen, rdy_mode, kidx;

    @(negedge clk);
    do_reset();
    hold(8'h00, 4);

    // press latency and press/release without repeats
    repeat_en = 1'b0;
    keycode = 8'h1A;
    lat = -1;
    lat_data = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (lat < 0 && ev_valid) begin lat = c; lat_data = ev_data; end
    end
    check_eq("press_latency", lat, 32'd4);
    check_eq("press_code", {22'd0, lat_data}, 32'h11A);
    hold(8'h1A, 20);
    hold(8'h00, 10);

    // typematic repeat, key swap, glitch
    repeat_en = 1'b1;
    hold(8'h04, 30);
    hold(8'h07, 12);
    check_eq("swap_cur_key", {24'd0, cur_key}, 32'h07);
    hold(8'h00, 8);
    hold(8'h16, 1);
    hold(8'h00, 8);

    // overflow with a stalled consumer, then drain and clear
    repeat_en = 1'b0;
    ev_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      hold(8'h21 + 8'(t), 6);
      hold(8'h00, 6);
    end
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    ev_ready = 1'b1;
    hold(8'h00, 8);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);

    // reset in the middle of a stalled stream
    ev_ready = 1'b0;
    repeat_en = 1'b1;
    hold(8'h2C, 20);
    do_reset();
    ev_ready = 1'b1;
    hold(8'h00, 3);

    // randomized segments
    for (int s = 0; s < 220; s++) begin
      kidx = int'($urandom_range(0, 6));
      hlen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(3, 30));
      if ($urandom_range(0, 3) == 0) repeat_en = ~repeat_en;
      rdy_mode = int'($urandom_range(0, 3));
      keycode = keys[kidx];
      for (int c = 0; c < hlen; c++) begin
        ev_ready = (rdy_mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        ovf_clr = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 19) == 0) repeat_en = ~repeat_en;
        step();
      end
      ovf_clr = 1'b0;
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keycode_event_sequencer.md
Name: keycode_event_sequencer

Overview:
- Converts the 8-bit level keycode driven by the NIOS-written keycode PIO into a stream of discrete key events: press, release and auto-repeat.
- Filters transient keycode values and schedules typematic repeats with delay and rate counters.
- Buffers events in a small show-ahead FIFO drained by the game logic over a valid/ready handshake.

Parameters:
- STABLE_CYCLES, 4, cycles a new keycode must hold unchanged before it is accepted (1..255)
- REPEAT_DELAY, 25000000, cycles from a press event to the first repeat event (>=2)
- REPEAT_RATE, 5000000, cycles between consecutive repeat events (>=2)
- DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- keycode  in  8  raw keycode from the PIO; 0x00 means no key
- repeat_en  in  1  1 = generate repeat events
- ev_valid  out  1  FIFO head is valid
- ev_data  out  10  {type[1:0], code[7:0]}; type 01 = press, 10 = release, 11 = repeat
- ev_ready  in  1  consumer accepts the head when ev_valid & ev_ready
- overflow  out  1  sticky: a press or release event was dropped
- ovf_clr  in  1  synchronous clear of overflow
- cur_key  out  8  currently accepted (filtered) keycode

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; counters 0. Reset asserted mid-operation discards FIFO contents and any pending event immediately.
- Filter:
  - keycode is registered once (1 cycle).
  - A stability counter restarts on every change of the registered value.
  - When the value has held for STABLE_CYCLES cycles and differs from cur_key, it becomes the candidate.
  - Latency from a keycode change to the press event appearing at ev_valid is 1 + STABLE_CYCLES + 1 cycles.
- FSM states: IDLE, DELAY, REPEAT, SWAP.
  - IDLE, candidate nonzero: push press(candidate); cur_key <= candidate; delay counter loaded with REPEAT_DELAY; go to DELAY.
  - DELAY / REPEAT, candidate 0x00: push release(cur_key); cur_key <= 0; go to IDLE.
  - DELAY / REPEAT, candidate nonzero and different from cur_key: push release(old cur_key) this cycle; go to SWAP. Next cycle push press(new); cur_key <= new; reload delay; go to DELAY. Filter changes arriving during the SWAP cycle are held until SWAP completes.
  - DELAY: counter decrements. At 0 with repeat_en=1: push repeat(cur_key), load REPEAT_RATE, go to REPEAT. If repeat_en=0 the counter stays at 0 and the FSM stays in DELAY with no events.
  - REPEAT: at 0 with repeat_en=1: push repeat(cur_key) and reload REPEAT_RATE.
  - repeat_en falling while in REPEAT: return to DELAY with the counter at 0 (no events until re-enabled).
- FIFO:
  - Show-ahead: ev_data is valid whenever ev_valid=1; the head is stable until it is popped.
  - Push is accepted when not full, or when full with a pop in the same cycle (simultaneous push and pop always succeed).
  - Simultaneous push and pop when empty: the event appears at the head the next cycle (no fall-through).
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally.
- Overflow:
  - A dropped press or release sets overflow; cur_key and the FSM still advance.
  - A dropped repeat is silent.
  - ovf_clr clears overflow; if a set and a clear occur in the same cycle, the set wins.
- Counters are sized to $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1) bits.

Decomposition:
- Shared package `keycode_pkg` holds:
  - the event type localparams EV_PRESS=2'b01, EV_RELEASE=2'b10, EV_REPEAT=2'b11;
  - KEY_NONE=8'h00;
  - the FSM state enum.
- One sub-module, `key_event_fifo`: a parameterised show-ahead FIFO with push/pop/full/empty, reused for the event buffer.

Test Plan:
Bench parameters: STABLE_CYCLES=2, REPEAT_DELAY=10, REPEAT_RATE=4, DEPTH=4, ev_ready=1 unless stated otherwise.
- keycode 0x00→0x1A held, repeat_en=0 → exactly one event 0x11A (press), ev_valid 4 cycles after the change; keycode→0x00 → 0x21A (release); no repeats.
- keycode 0x04 held for 30 cycles, repeat_en=1 → press 0x104, then repeat 0x304 at +10 cycles and every 4 cycles after: total 1 press + 5 repeats.
- keycode 0x04 held, then 0x07 held → release 0x204 followed immediately by press 0x107 on consecutive pushes; cur_key=0x07.
- 1-cycle glitch 0x00→0x16→0x00 → no events; cur_key stays 0x00.
- ev_ready=0, six press/release transitions → first 4 events retained in order, overflow=1; then ev_ready=1 → 4 events drained in order; assert ovf_clr → overflow=0.
- FIFO full with a push and a pop in the same cycle → no drop, overflow stays 0; reset_n pulsed mid-stream → ev_valid=0, cur_key=0, FSM in IDLE next cycle.
